// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 stream front end.
package sha256_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam int unsigned LEN_OFFSET  = 56;

  localparam logic [255:0] H_0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_ACCEPT,
    S_PAD,
    S_LAUNCH,
    S_WAIT,
    S_OUT
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_stream_if.sv
// Byte-stream input and digest output handshake bundle.
interface sha256_stream_if;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_empty;
  logic         in_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  modport master (
    output in_data, in_valid, in_last, in_empty, digest_ready,
    input  in_ready, digest, digest_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, in_empty, digest_ready,
    output in_ready, digest, digest_valid
  );
endinterface

// File: rtl/sha256_block.sv
// Iterative SHA-256 compression: one round per cycle, output_valid 65 cycles after launch.
module sha256_block
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         input_valid,
  input  logic [255:0] H_in,
  input  logic [511:0] M_in,
  output logic [255:0] H_out,
  output logic         output_valid
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] w [16];
  logic [6:0]  round;
  logic [31:0] t1, t2, w_new;

  // Round function and next schedule word from the 16-word sliding window.
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
           + K[round[5:0]] + w[0];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
          + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
  end

  // Load on launch, then run rounds until the counter saturates at 64 or above.
  always_ff @(posedge clk) begin
    output_valid <= !input_valid && (round == 7'd63);
    if (input_valid) begin
      {a, b, c, d, e, f, g, h} <= H_in;
      for (int unsigned i = 0; i < 16; i++) w[i] <= M_in[511 - 32*i -: 32];
      round <= '0;
    end else if (!round[6]) begin
      {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
      for (int unsigned i = 0; i < 15; i++) w[i] <= w[i + 1];
      w[15] <= w_new;
      round <= round + 7'd1;
    end
  end

  assign H_out = {H_in[255:224] + a, H_in[223:192] + b, H_in[191:160] + c, H_in[159:128] + d,
                  H_in[127:96]  + e, H_in[95:64]    + f, H_in[63:32]    + g, H_in[31:0]     + h};

endmodule

// File: rtl/sha256_pad.sv
// Combinational padding: end marker, zero fill and length field for the buffered block.
module sha256_pad
  import sha256_pkg::*;
(
  input  logic [511:0] blk_in,
  input  logic [6:0]   ptr,
  input  logic         marker_placed,
  input  logic [63:0]  bit_len,
  output logic [511:0] blk_out,
  output logic         final_blk
);

  // Marker and zero fill byte by byte, then the length field if it fits.
  always_comb begin
    blk_out   = blk_in;
    final_blk = 1'b0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (marker_placed || i > 32'(ptr)) begin
        blk_out[511 - 8*i -: 8] = '0;
      end else if (i == 32'(ptr)) begin
        blk_out[511 - 8*i -: 8] = 8'h80;
      end
    end
    if (marker_placed || ptr < 7'(LEN_OFFSET)) begin
      blk_out[63:0] = bit_len;
      final_blk     = 1'b1;
    end
  end

endmodule

// File: rtl/sha256_stream.sv
// Byte-stream front end: buffering, padding and hash chaining around sha256_block.
module sha256_stream
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 61
) (
  input logic            clk,
  input logic            rst,
  sha256_stream_if.slave st
);

  state_t             state, state_nxt;
  logic [511:0]       blk_buf;
  logic [6:0]         ptr;
  logic [LEN_W-1:0]   count;
  logic [255:0]       h_cur;
  logic               marker_placed, final_flag, pend_last;
  logic               core_in_valid, core_out_valid;
  logic [255:0]       core_h_out;
  logic [511:0]       pad_blk;
  logic               pad_final;
  logic [63:0]        bit_len;

  assign bit_len   = 64'({count, 3'b000});
  assign st.digest = h_cur;

  sha256_pad u_pad (
    .blk_in        (blk_buf),
    .ptr           (ptr),
    .marker_placed (marker_placed),
    .bit_len       (bit_len),
    .blk_out       (pad_blk),
    .final_blk     (pad_final)
  );

  sha256_block u_core (
    .clk          (clk),
    .input_valid  (core_in_valid),
    .H_in         (h_cur),
    .M_in         (blk_buf),
    .H_out        (core_h_out),
    .output_valid (core_out_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_ACCEPT;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt       = state;
    st.in_ready     = 1'b0;
    st.digest_valid = 1'b0;
    core_in_valid   = 1'b0;
    case (state)
      S_ACCEPT: begin
        st.in_ready = 1'b1;
        if (st.in_valid) begin
          if (!st.in_empty && ptr == 7'd63) state_nxt = S_LAUNCH;
          else if (st.in_last)              state_nxt = S_PAD;
        end
      end
      S_PAD:    state_nxt = S_LAUNCH;
      S_LAUNCH: begin
        core_in_valid = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        if (core_out_valid) begin
          if (final_flag)     state_nxt = S_OUT;
          else if (pend_last) state_nxt = S_PAD;
          else                state_nxt = S_ACCEPT;
        end
      end
      S_OUT: begin
        st.digest_valid = 1'b1;
        if (st.digest_ready) state_nxt = S_ACCEPT;
      end
      default: state_nxt = S_ACCEPT;
    endcase
  end

  // Buffer fill, padding, chaining value and message bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      count         <= '0;
      h_cur         <= H_0;
      marker_placed <= 1'b0;
      final_flag    <= 1'b0;
      pend_last     <= 1'b0;
    end else begin
      case (state)
        S_ACCEPT: begin
          if (st.in_valid) begin
            if (!st.in_empty) begin
              // 511-8*ptr == {63-ptr, 3'b111}, and 63-ptr == ~ptr[5:0] while ptr < 64.
              blk_buf[{~ptr[5:0], 3'b111} -: 8] <= st.in_data;
              ptr   <= ptr + 7'd1;
              count <= count + 1'b1;
            end
            if (st.in_last) pend_last <= 1'b1;
          end
        end
        S_PAD: begin
          blk_buf       <= pad_blk;
          marker_placed <= 1'b1;
          if (pad_final) final_flag <= 1'b1;
        end
        S_WAIT: begin
          if (core_out_valid) begin
            h_cur <= core_h_out;
            ptr   <= '0;
          end
        end
        S_OUT: begin
          if (st.digest_ready) begin
            h_cur         <= H_0;
            count         <= '0;
            marker_placed <= 1'b0;
            final_flag    <= 1'b0;
            pend_last     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream.sv
// Self-checking bench for sha256_stream against a software SHA-256 model.
module tb_sha256_stream;

  typedef logic [7:0] bq_t [$];

  localparam logic [31:0] HREF [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] KREF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H0_ALL = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_56   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sha256_stream_if tif ();

  sha256_stream #(.LEN_W(61)) dut (
    .clk (clk),
    .rst (rst),
    .st  (tif)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [511:0] blocks [$];

  // Record every block handed to the core.
  always @(negedge clk) begin
    if (!rst && dut.core_in_valid) blocks.push_back(dut.blk_buf);
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_ref(input bq_t msg);
    bq_t p;
    logic [63:0] bl;
    logic [31:0] hh [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    for (int i = 0; i < 8; i++) hh[i] = HREF[i];
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[blk*64 + 4*t], p[blk*64 + 4*t + 1], p[blk*64 + 4*t + 2], p[blk*64 + 4*t + 3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
      e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KREF[t] + w[t];
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
      hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tif.in_valid = 1'b0; tif.in_last = 1'b0; tif.in_empty = 1'b0;
    tif.in_data = 8'h00; tif.digest_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    blocks.delete();
  endtask

  task automatic send_msg(input bq_t msg, input int unsigned gap_pct);
    int unsigned nb;
    nb = (msg.size() == 0) ? 1 : msg.size();
    for (int unsigned i = 0; i < nb; i++) begin
      int n;
      while ($urandom_range(99) < gap_pct) begin
        tif.in_valid = 1'b0;
        step();
      end
      tif.in_valid = 1'b1;
      tif.in_empty = (msg.size() == 0);
      tif.in_data  = (msg.size() == 0) ? 8'h00 : msg[i];
      tif.in_last  = (i == nb - 1);
      n = 0;
      while (!tif.in_ready && n < 300) begin
        step();
        n++;
      end
      if (!tif.in_ready) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready=%0b required 1 within 300 cycles", tif.in_ready);
      end
      step();
    end
    tif.in_valid = 1'b0; tif.in_last = 1'b0; tif.in_empty = 1'b0;
  endtask

  task automatic get_digest(output logic [255:0] d);
    int n = 0;
    while (!tif.digest_valid && n < 400) begin
      step();
      n++;
    end
    if (!tif.digest_valid) begin
      n_checks++; n_fail++;
      $display("FAIL digest_timeout: digest_valid=%0b required 1 within 400 cycles", tif.digest_valid);
      d = '0;
    end else begin
      d = tif.digest;
      tif.digest_ready = 1'b1;
      step();
      tif.digest_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (tif.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", tif.in_ready);
    end
    n_checks++;
    if (tif.digest_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_digest_valid: got %b expected 0", tif.digest_valid);
    end
    n_checks++;
    if (tif.digest !== H0_ALL) begin
      n_fail++; $display("FAIL reset_digest: got %h expected %h", tif.digest, H0_ALL);
    end
  endtask

  task automatic test_abc_timing();
    bq_t m;
    logic [255:0] d;
    int c;
    m = str2q("abc");
    blocks.delete();
    for (int i = 0; i < 3; i++) begin
      tif.in_valid = 1'b1; tif.in_data = m[i]; tif.in_last = (i == 2); tif.in_empty = 1'b0;
      n_checks++;
      if (tif.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL abc_accept_ready[%0d]: got %b expected 1", i, tif.in_ready);
      end
      step();
    end
    tif.in_valid = 1'b0; tif.in_last = 1'b0;
    n_checks++;
    if (tif.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abc_pad_ready: got %b expected 0", tif.in_ready);
    end
    c = 3;
    while (!tif.digest_valid && c < 300) begin
      step();
      c++;
    end
    n_checks++;
    if (c != 70) begin
      n_fail++; $display("FAIL abc_latency: digest_valid first at cycle %0d expected 70", c);
    end
    get_digest(d);
    n_checks++;
    if (d !== D_ABC) begin
      n_fail++; $display("FAIL abc_digest: got %h expected %h", d, D_ABC);
    end
    n_checks++;
    if (blocks.size() != 1) begin
      n_fail++; $display("FAIL abc_launches: got %0d expected 1", blocks.size());
    end else begin
      n_checks++;
      if (blocks[0] !== {24'h616263, 8'h80, 416'd0, 64'h18}) begin
        n_fail++; $display("FAIL abc_block: got %h expected padded abc", blocks[0]);
      end
    end
  endtask

  task automatic test_empty();
    bq_t m;
    logic [255:0] d;
    blocks.delete();
    send_msg(m, 0);
    get_digest(d);
    n_checks++;
    if (d !== D_EMPTY) begin
      n_fail++; $display("FAIL empty_digest: got %h expected %h", d, D_EMPTY);
    end
    n_checks++;
    if (blocks.size() != 1) begin
      n_fail++; $display("FAIL empty_launches: got %0d expected 1", blocks.size());
    end
  endtask

  task automatic test_56();
    bq_t m;
    logic [255:0] d;
    m = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    blocks.delete();
    send_msg(m, 20);
    get_digest(d);
    n_checks++;
    if (d !== D_56) begin
      n_fail++; $display("FAIL m56_digest: got %h expected %h", d, D_56);
    end
    n_checks++;
    if (blocks.size() != 2) begin
      n_fail++; $display("FAIL m56_launches: got %0d expected 2", blocks.size());
    end else begin
      n_checks++;
      if (blocks[1] !== 512'h1c0) begin
        n_fail++; $display("FAIL m56_block2: got %h expected zeros+1c0", blocks[1]);
      end
    end
  endtask

  task automatic test_64a();
    bq_t m;
    logic [255:0] d, exp_d;
    for (int i = 0; i < 64; i++) m.push_back(8'h61);
    exp_d = sha_ref(m);
    blocks.delete();
    send_msg(m, 0);
    get_digest(d);
    n_checks++;
    if (d !== exp_d) begin
      n_fail++; $display("FAIL m64_digest: got %h expected %h", d, exp_d);
    end
    n_checks++;
    if (blocks.size() != 2) begin
      n_fail++; $display("FAIL m64_launches: got %0d expected 2", blocks.size());
    end else begin
      n_checks++;
      if (blocks[1] !== {8'h80, 440'd0, 64'h200}) begin
        n_fail++; $display("FAIL m64_block2: got %h expected 80,zeros,200", blocks[1]);
      end
    end
  endtask

  task automatic test_random();
    int unsigned lens [8];
    lens = '{55, 63, 119, 120, 1, 0, 0, 0};
    for (int k = 5; k < 8; k++) lens[k] = $urandom_range(0, 140);
    for (int k = 0; k < 8; k++) begin
      bq_t m;
      logic [255:0] d, exp_d;
      int unsigned exp_l;
      for (int unsigned i = 0; i < lens[k]; i++) m.push_back(8'($urandom));
      exp_d = sha_ref(m);
      exp_l = (lens[k] + 8) / 64 + 1;
      blocks.delete();
      send_msg(m, 30);
      get_digest(d);
      n_checks++;
      if (d !== exp_d) begin
        n_fail++; $display("FAIL rand_digest len=%0d: got %h expected %h", lens[k], d, exp_d);
      end
      n_checks++;
      if (blocks.size() != exp_l) begin
        n_fail++; $display("FAIL rand_launches len=%0d: got %0d expected %0d", lens[k], blocks.size(), exp_l);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d;
    int bad;
    send_msg(str2q("abc"), 0);
    bad = 0;
    while (!tif.digest_valid && bad < 300) begin
      step();
      bad++;
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (tif.digest_valid !== 1'b1 || tif.digest !== D_ABC || tif.in_ready !== 1'b0) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL hold_stable: %0d unstable cycles, expected 0 (valid=%b ready=%b digest=%h)",
                         bad, tif.digest_valid, tif.in_ready, tif.digest);
    end
    tif.digest_ready = 1'b1;
    step();
    tif.digest_ready = 1'b0;
    n_checks++;
    if (tif.in_ready !== 1'b1 || tif.digest_valid !== 1'b0) begin
      n_fail++; $display("FAIL release_accept: in_ready=%b digest_valid=%b expected 1/0", tif.in_ready, tif.digest_valid);
    end
    send_msg(str2q("abc"), 0);
    get_digest(d);
    n_checks++;
    if (d !== D_ABC) begin
      n_fail++; $display("FAIL after_release_digest: got %h expected %h", d, D_ABC);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    int spurious;
    send_msg(str2q("abc"), 0);
    repeat (32) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (tif.in_ready !== 1'b1 || tif.digest_valid !== 1'b0 || tif.digest !== H0_ALL) begin
      n_fail++; $display("FAIL midrst_state: in_ready=%b valid=%b digest=%h expected 1/0/H0",
                         tif.in_ready, tif.digest_valid, tif.digest);
    end
    spurious = 0;
    for (int i = 0; i < 80; i++) begin
      if (tif.digest_valid !== 1'b0 || tif.digest !== H0_ALL) spurious++;
      step();
    end
    n_checks++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL midrst_spurious: %0d cycles disturbed, expected 0", spurious);
    end
    send_msg(str2q("abc"), 0);
    get_digest(d);
    n_checks++;
    if (d !== D_ABC) begin
      n_fail++; $display("FAIL midrst_digest: got %h expected %h", d, D_ABC);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_abc_timing();
    test_empty();
    test_56();
    test_64a();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_stream.md
# sha256_stream

Byte-stream front end and chaining controller for the SHA-256 block processor `sha256_block`. It accepts a message one byte per cycle, applies FIPS 180-4 padding and the 64-bit length field, and presents 512-bit blocks to `sha256_block`. It chains intermediate hash values between blocks and presents the final 256-bit digest on a valid/ready output.

## Interface
- `LEN_W`, default 61: width of the byte counter. Message bit length is `{count, 3'b0}`, zero-extended to 64 bits.
- `clk`  in  1  clock
- `rst`  in  1  reset; already decided as synchronous, active-high
- `in_data`  in  8  message byte
- `in_valid`  in  1  input beat valid
- `in_last`  in  1  beat is the final one of the message
- `in_empty`  in  1  beat carries no byte; legal only with `in_last` (empty message or terminator)
- `in_ready`  out  1  beat accepted when `in_valid & in_ready`
- `digest`  out  256  final hash; H0 at [255:224]
- `digest_valid`  out  1  digest available
- `digest_ready`  in  1  consumer accepts the digest

## Operation
- State machine: ACCEPT, PAD, LAUNCH, WAIT, OUT. Registers:
  - `buf[511:0]`
  - `ptr[6:0]` (bytes in buffer, 0..64)
  - `count`
  - `H_cur[255:0]`
  - flags `marker_placed`, `final`
- ACCEPT
  - `in_ready = 1`.
  - An accepted byte goes to `buf[511-8*ptr -: 8]` (first byte is MSB, big-endian); `ptr` and `count` increment.
  - If `ptr` becomes 64, the next state is LAUNCH.
  - A beat with `in_last` (byte or empty) sets a pending-last condition.
    - If the buffer is not full, the next state is PAD.
    - If the buffer is full, the next state is LAUNCH, with padding deferred to after that block completes.
- PAD (one cycle)
  - If `!marker_placed`: byte[`ptr`] = 0x80 and bytes above it = 0; set `marker_placed`.
  - If `marker_placed` was already set: all bytes = 0.
  - If the 0x80 position is ≤ 55, or `marker_placed` was already set: write the bit length to `buf[63:0]` and set `final`.
  - Next state: LAUNCH.
- LAUNCH (one cycle)
  - Drive core `input_valid = 1`, `H_in = H_cur`, `M_in = buf`.
- WAIT
  - Core `input_valid = 0`. `H_in` and `M_in` are held stable throughout.
  - On core `output_valid`: `H_cur <= H_out` and `ptr <= 0`.
  - Next state:
    - `final` set: OUT.
    - pending-last set: PAD.
    - otherwise: ACCEPT.
- OUT
  - `digest = H_cur`, `digest_valid = 1`.
  - On `digest_ready`: `H_cur <= H_0`, all flags and `count` clear, next state ACCEPT.
- The core has no reset and its `round` counter is undefined after power-up. Core `output_valid` is ignored in every state except WAIT.
- `count` wraps modulo 2^LEN_W; no overflow error is reported.

## Timing
- Reset values:
  - state ACCEPT
  - `in_ready = 1`, `digest_valid = 0`, `digest = H_0`
  - `ptr = 0`, `count = 0`, all flags 0
  - core `input_valid = 0`
- Core latency: `output_valid` occurs 65 cycles after the LAUNCH cycle.
- Per-block overhead beyond the accepted bytes is LAUNCH (1) + WAIT (65) cycles; PAD adds 1 cycle.
- A 3-byte message gives:
  - `in_ready` high for 3 accept cycles
  - PAD at cycle 3, LAUNCH at 4, core `output_valid` at 69
  - `digest_valid` high from cycle 70
- After a non-final block, `in_ready` reasserts the cycle after core `output_valid`.
- `in_ready` is 0 in PAD, LAUNCH, WAIT and OUT. A new message cannot start in the same cycle the digest is accepted.
- `digest` and `digest_valid` are stable while `digest_ready` is low.
- `rst` mid-message or mid-WAIT aborts the operation and restores all reset values next cycle. A launched core computation is abandoned and its `output_valid` is ignored.

## Structure
- Package `sha256_pkg` holds:
  - the H_0 initial-value constant
  - `BLOCK_BYTES = 64`
  - `LEN_OFFSET = 56`
  - the state enum
- Instantiates `sha256_block`.
- One natural combinational sub-module: `sha256_pad`. Inputs are `buf`, `ptr`, `marker_placed` and bit length; outputs are the padded block and `final`.

## Test plan
- "abc" then `in_last` → digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; exactly 1 core launch.
- Single beat with `in_empty & in_last` → digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; 1 launch.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; 2 launches, second block = zeros + length 0x1C0.
- 64 bytes of 0x61 with `in_last` on byte 64 → 2 launches, second block = 0x80, zeros, length 0x200; digest matches the software model.
- Hold `digest_ready` low for 20 cycles → `digest_valid` and `digest` are stable and `in_ready = 0`. Release → ACCEPT next cycle, and a following "abc" hashes correctly.
- Assert `rst` at WAIT cycle 30 of "abc", then resend "abc" → no spurious digest, and the correct "abc" digest is produced.
